// File: rtl/mem_arb.sv
// mem_arb: two-requester round-robin arbiter in front of a single-port memory.
// A request sampled in IDLE is captured, issued to the memory for one ACCESS
// cycle (with the requester's grant), and, for reads, the memory's response is
// captured one cycle later and returned with a one-cycle rvalid pulse.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req/we/addr/wdata 0,1    requester transaction inputs, held until grant
//   gnt0, gnt1               one-cycle grant pulses
//   rvalid0/1, rdata0/1      read return (rdata holds until the next read)
//   mem_read, mem_write      memory strobes, high only in ACCESS
//   mem_addr, mem_data_in    memory address and write data
//   mem_data_out             memory read data, valid the cycle after mem_read
module mem_arb #(
   parameter int unsigned DEPTH = 32,
   parameter int unsigned WIDTH = 8,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic             req1,
   input  logic             we0,
   input  logic             we1,
   input  logic [AW-1:0]    addr0,
   input  logic [AW-1:0]    addr1,
   input  logic [WIDTH-1:0] wdata0,
   input  logic [WIDTH-1:0] wdata1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             rvalid0,
   output logic             rvalid1,
   output logic [WIDTH-1:0] rdata0,
   output logic [WIDTH-1:0] rdata1,
   output logic             mem_read,
   output logic             mem_write,
   output logic [AW-1:0]    mem_addr,
   output logic [WIDTH-1:0] mem_data_in,
   input  logic [WIDTH-1:0] mem_data_out
);

   // The address bus must be able to reach every word of the memory.
   if (AW < $clog2(DEPTH)) begin : g_aw_check
      $error("mem_arb: AW too narrow for DEPTH");
   end

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RDWAIT = 2'd2
   } state_t;

   state_t state;
   logic   last;     // last-served requester
   logic   cur_id;   // requester owning the in-flight transaction
   logic   cur_we;   // in-flight transaction is a write
   logic   pick1;

   // Requester 1 wins when alone, or when both ask and 0 was served last.
   assign pick1 = req1 & (~req0 | ~last);

   // Arbitration, memory sequencing and read return.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         last        <= 1'b1;
         cur_id      <= 1'b0;
         cur_we      <= 1'b0;
         gnt0        <= 1'b0;
         gnt1        <= 1'b0;
         rvalid0     <= 1'b0;
         rvalid1     <= 1'b0;
         rdata0      <= '0;
         rdata1      <= '0;
         mem_read    <= 1'b0;
         mem_write   <= 1'b0;
         mem_addr    <= '0;
         mem_data_in <= '0;
      end else begin
         // Pulses default low; set only on the cycle they are due.
         gnt0      <= 1'b0;
         gnt1      <= 1'b0;
         rvalid0   <= 1'b0;
         rvalid1   <= 1'b0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  cur_id      <= pick1;
                  last        <= pick1;
                  cur_we      <= pick1 ? we1 : we0;
                  gnt0        <= ~pick1;
                  gnt1        <= pick1;
                  mem_write   <= pick1 ? we1 : we0;
                  mem_read    <= pick1 ? ~we1 : ~we0;
                  mem_addr    <= pick1 ? addr1 : addr0;
                  mem_data_in <= pick1 ? wdata1 : wdata0;
                  state       <= ACCESS;
               end
            end
            ACCESS: begin
               state <= cur_we ? IDLE : RDWAIT;
            end
            RDWAIT: begin
               // Memory data is valid now, one cycle after the read strobe.
               if (cur_id) begin
                  rdata1  <= mem_data_out;
                  rvalid1 <= 1'b1;
               end else begin
                  rdata0  <= mem_data_out;
                  rvalid0 <= 1'b1;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed self-checking bench for mem_arb with a behavioural
// 32x8 memory (registered read, one-cycle latency).
module tb_mem_arb;

   localparam int unsigned DEPTH = 32;
   localparam int unsigned WIDTH = 8;
   localparam int unsigned AW    = 5;

   logic             clk, rst;
   logic             req0, req1, we0, we1;
   logic [AW-1:0]    addr0, addr1;
   logic [WIDTH-1:0] wdata0, wdata1;
   logic             gnt0, gnt1, rvalid0, rvalid1;
   logic [WIDTH-1:0] rdata0, rdata1;
   logic             mem_read, mem_write;
   logic [AW-1:0]    mem_addr;
   logic [WIDTH-1:0] mem_data_in, mem_data_out;

   int errors = 0;
   int checks = 0;
   logic load;
   logic [WIDTH-1:0] mem [DEPTH];
   logic prev_rd;

   mem_arb #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata0(rdata0), .rdata1(rdata1),
      .mem_read(mem_read), .mem_write(mem_write),
      .mem_addr(mem_addr), .mem_data_in(mem_data_in),
      .mem_data_out(mem_data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model; preload gives mem[i] = i ^ 0x5A.
   always @(posedge clk) begin
      if (load) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= 8'(i) ^ 8'h5A;
         mem_data_out <= '0;
      end else begin
         if (mem_write) mem[mem_addr] <= mem_data_in;
         if (mem_read)  mem_data_out  <= mem[mem_addr];
      end
   end

   // Protocol checks every cycle outside reset.
   always @(negedge clk) begin
      if (rst) begin
         prev_rd <= 1'b0;
      end else begin
         checks = checks + 3;
         assert (!(mem_read && mem_write)) else begin
            errors++;
            $error("FAIL rd_wr_both observed=1 expected=0");
         end
         assert (!(gnt0 && gnt1)) else begin
            errors++;
            $error("FAIL gnt_both observed=1 expected=0");
         end
         assert (!(prev_rd && mem_read)) else begin
            errors++;
            $error("FAIL rd_adjacent observed=1 expected=0");
         end
         prev_rd <= mem_read;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_gnt"},    {30'd0, gnt1, gnt0}, 32'd0);
      chk({tag, "_rvalid"}, {30'd0, rvalid1, rvalid0}, 32'd0);
      chk({tag, "_rdata"},  {16'd0, rdata1, rdata0}, 32'd0);
      chk({tag, "_strobe"}, {30'd0, mem_read, mem_write}, 32'd0);
      chk({tag, "_maddr"},  32'(mem_addr), 32'd0);
      chk({tag, "_mdata"},  32'(mem_data_in), 32'd0);
   endtask

   initial begin
      rst = 1'b1; load = 1'b1;
      req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      step(); step();
      chk_all_zero("reset");
      rst = 1'b0; load = 1'b0;

      // Write 0xA5 to address 5 from requester 0.
      req0 = 1'b1; we0 = 1'b1; addr0 = 5'd5; wdata0 = 8'hA5;
      step();
      chk("wr_gnt",   {30'd0, gnt1, gnt0}, 32'b01);
      chk("wr_strb",  {30'd0, mem_read, mem_write}, 32'b01);
      chk("wr_addr",  32'(mem_addr), 32'd5);
      chk("wr_data",  32'(mem_data_in), 32'hA5);
      req0 = 1'b0;
      step();
      chk("wr_done",  {29'd0, gnt0, mem_write, mem_read}, 32'd0);

      // Read it back.
      req0 = 1'b1; we0 = 1'b0; addr0 = 5'd5;
      step();
      chk("rd_gnt",   {30'd0, gnt1, gnt0}, 32'b01);
      chk("rd_strb",  {30'd0, mem_read, mem_write}, 32'b10);
      chk("rd_addr",  32'(mem_addr), 32'd5);
      req0 = 1'b0;
      step();
      chk("rd_wait",  {30'd0, rvalid0, mem_read}, 32'd0);
      step();
      chk("rd_valid", 32'(rvalid0), 32'd1);
      chk("rd_data",  32'(rdata0), 32'hA5);
      step();
      chk("rd_pulse", 32'(rvalid0), 32'd0);
      chk("rd_hold",  32'(rdata0), 32'hA5);

      // Reset restores pointer and clears captured data.
      rst = 1'b1;
      step();
      chk_all_zero("reset2");
      rst = 1'b0;

      // Contention: both writing, held high -> 0,1,0,1.
      req0 = 1'b1; we0 = 1'b1; addr0 = 5'd1; wdata0 = 8'h11;
      req1 = 1'b1; we1 = 1'b1; addr1 = 5'd2; wdata1 = 8'h22;
      step();
      chk("ct_g1",    {30'd0, gnt1, gnt0}, 32'b01);
      chk("ct_a1",    32'(mem_addr), 32'd1);
      step();
      chk("ct_gap1",  {30'd0, gnt1, gnt0}, 32'b00);
      step();
      chk("ct_g2",    {30'd0, gnt1, gnt0}, 32'b10);
      chk("ct_a2",    32'(mem_addr), 32'd2);
      chk("ct_d2",    32'(mem_data_in), 32'h22);
      step();
      step();
      chk("ct_g3",    {30'd0, gnt1, gnt0}, 32'b01);
      step();
      step();
      chk("ct_g4",    {30'd0, gnt1, gnt0}, 32'b10);
      req0 = 1'b0; req1 = 1'b0;
      step();

      // Lone requester 1 (pointer at 1), read addr 31 held across two grants.
      req1 = 1'b1; we1 = 1'b0; addr1 = 5'd31;
      step();
      chk("lone_gnt", {30'd0, gnt1, gnt0}, 32'b10);
      chk("lone_rd",  32'(mem_read), 32'd1);
      chk("lone_a",   32'(mem_addr), 32'd31);
      step();
      chk("b2b_wait", {30'd0, gnt1, mem_read}, 32'd0);
      step();
      chk("b2b_rv1",  {30'd0, rvalid1, gnt1}, 32'b10);
      chk("b2b_rd1",  32'(rdata1), 32'h45);
      step();
      chk("b2b_g2",   {30'd0, gnt1, mem_read}, 32'b11);
      chk("b2b_rv0",  32'(rvalid1), 32'd0);
      req1 = 1'b0;
      step();
      step();
      chk("b2b_rv2",  32'(rvalid1), 32'd1);
      chk("b2b_rd2",  32'(rdata1), 32'h45);
      chk("b2b_rv0b", 32'(rvalid0), 32'd0);
      step();
      chk("b2b_end",  32'(rvalid1), 32'd0);

      // Reset during RDWAIT aborts the read.
      req0 = 1'b1; we0 = 1'b0; addr0 = 5'd5;
      step();
      chk("ab_gnt",   32'(gnt0), 32'd1);
      req0 = 1'b0;
      step();
      rst = 1'b1;
      #1;
      chk_all_zero("ab_rst");
      step();
      rst = 1'b0;
      step();
      chk("ab_rv",    {30'd0, rvalid1, rvalid0}, 32'd0);
      chk("ab_gnt2",  {30'd0, gnt1, gnt0}, 32'd0);
      req0 = 1'b1; we0 = 1'b1; addr0 = 5'd3; wdata0 = 8'h33;
      req1 = 1'b1; we1 = 1'b1; addr1 = 5'd4; wdata1 = 8'h44;
      step();
      chk("ab_ct",    {30'd0, gnt1, gnt0}, 32'b01);
      chk("ab_ct_a",  32'(mem_addr), 32'd3);
      req0 = 1'b0; req1 = 1'b0;
      step();
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter DEPTH, default 32, memory word count.
REQ-002 Parameter WIDTH, default 8, data word width in bits.
REQ-003 Parameter AW, default $clog2(DEPTH) (5), address width.
REQ-004 The block SHALL have exactly one clock and one reset; reset is asynchronous and active-high.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 req0, req1  input  1 each  requester N transaction request, held high until grantN.
REQ-008 we0, we1  input  1 each  requester N direction: 1 = write, 0 = read; stable while reqN high.
REQ-009 addr0, addr1  input  AW each  requester N word address; stable while reqN high.
REQ-010 wdata0, wdata1  input  WIDTH each  requester N write data; stable while reqN high.
REQ-011 gnt0, gnt1  output  1 each  one-cycle pulse: requester N transaction accepted.
REQ-012 rvalid0, rvalid1  output  1 each  one-cycle pulse: rdataN holds read result.
REQ-013 rdata0, rdata1  output  WIDTH each  read data for requester N.
REQ-014 mem_read  output  1  memory read strobe.
REQ-015 mem_write  output  1  memory write strobe.
REQ-016 mem_addr  output  AW  memory address.
REQ-017 mem_data_in  output  WIDTH  data to memory.
REQ-018 mem_data_out  input  WIDTH  data from memory, valid the cycle after mem_read is high.

Function
REQ-019 FSM states are IDLE, ACCESS and RDWAIT, and all outputs SHALL be driven from registers.
REQ-020 In IDLE with any reqN high at edge E, the FSM SHALL select a winner, capture its we/addr/wdata, and go to ACCESS.
REQ-021 In the ACCESS cycle (E+1), the block SHALL assert gntN of the winner together with mem_read=!we or mem_write=we, mem_addr, and mem_data_in=wdata.
REQ-022 For a write, ACCESS SHALL return to IDLE, so the next arbitration samples in cycle E+2.
REQ-023 For a read, ACCESS SHALL go to RDWAIT, and RDWAIT SHALL capture mem_data_out into rdataN of the winner.
REQ-024 After RDWAIT, rvalidN SHALL pulse for one cycle (E+3) while the FSM is in IDLE and may arbitrate again in that cycle.
REQ-025 Arbitration SHALL be round-robin: a last-served pointer is updated on each grant, and when both requesters are high the one not last served wins.
REQ-026 A lone requester SHALL win regardless of the pointer.
REQ-027 mem_read and mem_write SHALL never be high in the same cycle, and each SHALL be high only in ACCESS.
REQ-028 At most one gntN and at most one rvalidN SHALL be high per cycle; gnt0/gnt1 and rvalid0/rvalid1 SHALL be low outside their pulse cycles.
REQ-029 rdataN SHALL hold its last captured value until the next read by requester N.
REQ-030 reqN dropped before it is sampled in IDLE SHALL produce no transaction; reqN changes after capture SHALL be ignored until IDLE.
REQ-031 Addresses SHALL pass through unchanged, with no range check; the address width is AW.

Reset
REQ-032 While rst is high, the FSM SHALL be in IDLE and all outputs 0, including rdata0/rdata1, mem_addr and mem_data_in.
REQ-033 The last-served pointer SHALL reset to 1 so that requester 0 wins the first contention.
REQ-034 rst asserted during ACCESS or RDWAIT SHALL abort the transaction immediately, with no gnt or rvalid pulse after reset.

Verification
REQ-035 Write then read: req0 write addr 5 data 0xA5 -> gnt0 and mem_write with mem_addr=5, mem_data_in=0xA5 in E+1; then req0 read addr 5 -> rvalid0=1, rdata0=0xA5 three cycles after sampling.
REQ-036 Contention after reset: req0 and req1 both high -> gnt0 first, then gnt1; with both held high, grants alternate 0,1,0,1.
REQ-037 Back-to-back reads: req1 read addr 31 held across two grants -> rvalid1 at E+3, next gnt1 at E+4; mem_read is never high in adjacent cycles.
REQ-038 Reset mid-read: rst pulsed during RDWAIT -> rvalid0/rvalid1 stay 0, all outputs 0, and the next contention grants requester 0.
REQ-039 Lone requester: req1 alone with the pointer at 1 -> gnt1 granted, with no idle wait.
REQ-040 Protocol assertions: mem_read and mem_write are never both high, and gnt0 and gnt1 are never both high.
